thor_regfile_wr_arbiter: RTL and testbench

Schedules register write-back from four result sources onto the two write ports of the Thor 2-write/6-read register file. Each cycle it picks up to two requests in round-robin order. It never issues two writes to the same address in one cycle, suppresses writes to the hard-wired zero registers, and drives registered wr0/wr1/wa0/wa1/i0/i1 straight into the register file. It sits between the commit/result buses and the register file.

---
 rtl/thor_regfile_wr_arbiter_if.sv | 28 ++
 rtl/thor_regfile_wr_arbiter.sv | 106 ++++++++++
 tb/tb_thor_regfile_wr_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/thor_regfile_wr_arbiter_if.sv
// Request/write-back bundle between the result buses, the write arbiter and
// the Thor 2-write/6-read register file.
interface thor_regfile_wr_arbiter_if #(
    parameter int WID  = 64,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]       req_v;
    logic [8*NREQ-1:0]     req_addr;
    logic [WID*NREQ-1:0]   req_data;
    logic [NREQ-1:0]       req_rdy;
    logic                  wr0;
    logic [7:0]            wa0;
    logic [WID-1:0]        i0;
    logic                  wr1;
    logic [7:0]            wa1;
    logic [WID-1:0]        i1;
    logic [31:0]           wr_cnt;

    modport master (
        output req_v, req_addr, req_data,
        input  req_rdy, wr0, wa0, i0, wr1, wa1, i1, wr_cnt
    );

    modport slave (
        input  req_v, req_addr, req_data,
        output req_rdy, wr0, wa0, i0, wr1, wa1, i1, wr_cnt
    );
endinterface

// File: rtl/thor_regfile_wr_arbiter.sv
// Round-robin scheduler of four write-back requesters onto two register file
// write ports; never issues two same-address writes and drops zero-register writes.
module thor_regfile_wr_arbiter #(
    parameter int WID  = 64,
    parameter int NREQ = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    thor_regfile_wr_arbiter_if.slave bus
);
    logic [NREQ-1:0][7:0]     addr;
    logic [NREQ-1:0][WID-1:0] data;

    for (genvar n = 0; n < NREQ; n++) begin : g_unpack
        assign addr[n] = bus.req_addr[8*n +: 8];
        assign data[n] = bus.req_data[WID*n +: WID];
    end

    logic [1:0]      rr_q, rr_d;
    logic            a_v, b_v;
    logic [1:0]      a_idx, b_idx, idx;
    logic [NREQ-1:0] rdy;

    // Port 0 takes the first valid requester in scan order, port 1 the next
    // valid one whose address differs; conflicting requesters wait a cycle.
    always_comb begin
        a_v   = 1'b0;
        b_v   = 1'b0;
        a_idx = '0;
        b_idx = '0;
        idx   = '0;
        rdy   = '0;
        if (!rst && !stall) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = rr_q + 2'(k);
                if (bus.req_v[idx]) begin
                    if (!a_v) begin
                        a_v   = 1'b1;
                        a_idx = idx;
                    end else if (!b_v && addr[idx] != addr[a_idx]) begin
                        b_v   = 1'b1;
                        b_idx = idx;
                    end
                end
            end
            if (a_v) rdy[a_idx] = 1'b1;
            if (b_v) rdy[b_idx] = 1'b1;
        end
    end

    assign bus.req_rdy = rdy;

    always_comb begin
        rr_d = rr_q;
        if (b_v)      rr_d = b_idx + 2'd1;
        else if (a_v) rr_d = a_idx + 2'd1;
    end

    logic           wr0_q, wr0_d, wr1_q, wr1_d;
    logic [7:0]     wa0_q, wa0_d, wa1_q, wa1_d;
    logic [WID-1:0] i0_q, i0_d, i1_q, i1_d;
    logic [31:0]    cnt_q, cnt_d;

    // Zero registers (low six address bits clear in any bank) consume a slot
    // but never raise a strobe.
    always_comb begin
        wr0_d = a_v && (addr[a_idx][5:0] != 6'd0);
        wr1_d = b_v && (addr[b_idx][5:0] != 6'd0);
        wa0_d = a_v ? addr[a_idx] : wa0_q;
        i0_d  = a_v ? data[a_idx] : i0_q;
        wa1_d = b_v ? addr[b_idx] : wa1_q;
        i1_d  = b_v ? data[b_idx] : i1_q;
        cnt_d = cnt_q + 32'(wr0_q) + 32'(wr1_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q  <= '0;
            wr0_q <= 1'b0;
            wr1_q <= 1'b0;
            wa0_q <= '0;
            wa1_q <= '0;
            i0_q  <= '0;
            i1_q  <= '0;
            cnt_q <= '0;
        end else begin
            rr_q  <= rr_d;
            wr0_q <= wr0_d;
            wr1_q <= wr1_d;
            wa0_q <= wa0_d;
            wa1_q <= wa1_d;
            i0_q  <= i0_d;
            i1_q  <= i1_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.wr0    = wr0_q;
    assign bus.wa0    = wa0_q;
    assign bus.i0     = i0_q;
    assign bus.wr1    = wr1_q;
    assign bus.wa1    = wa1_q;
    assign bus.i1     = i1_q;
    assign bus.wr_cnt = cnt_q;
endmodule

// File: tb/tb_thor_regfile_wr_arbiter.sv
// Directed and randomized check of the write-back arbiter against a
// list-based scheduling model of the four requesters.
module tb_thor_regfile_wr_arbiter;
    localparam int WID = 64;

    logic clk = 1'b0;
    logic rst, stall;
    always #5 clk = ~clk;

    thor_regfile_wr_arbiter_if #(.WID(WID), .NREQ(4)) bus ();

    thor_regfile_wr_arbiter #(.WID(WID), .NREQ(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [3:0]     r_v;
    logic [7:0]     r_addr [4];
    logic [WID-1:0] r_data [4];

    // Reference state: what the register file should see next, and the pointer.
    int             m_rr;
    logic           m_wr0, m_wr1;
    logic [7:0]     m_wa0, m_wa1;
    logic [WID-1:0] m_i0, m_i1;
    logic [31:0]    m_cnt;
    bit             outs_known = 0;
    logic [3:0]     last_gnt, dut_rdy;

    task automatic chk(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int n = 0; n < 4; n++) begin
            bus.req_v[n]              = r_v[n];
            bus.req_addr[8*n +: 8]    = r_addr[n];
            bus.req_data[WID*n +: WID] = r_data[n];
        end
    endtask

    // One clock: check combinational grants and registered outputs mid-cycle,
    // then advance the model as the clock edge would. want[4] enables an extra
    // directed check of the grant vector against want[3:0].
    task automatic cycle(input logic [4:0] want);
        int order [$];
        int ga, gb;
        logic [3:0] er;
        drive();
        @(negedge clk);
        ga = -1; gb = -1; er = '0;
        if (!rst && !stall) begin
            for (int k = 0; k < 4; k++) order.push_back((m_rr + k) % 4);
            foreach (order[j]) begin
                if (r_v[order[j]]) begin
                    if (ga < 0) ga = order[j];
                    else if (gb < 0 && r_addr[order[j]] != r_addr[ga]) gb = order[j];
                end
            end
        end
        if (ga >= 0) er[ga] = 1'b1;
        if (gb >= 0) er[gb] = 1'b1;
        dut_rdy = bus.req_rdy;
        chk("req_rdy", WID'(bus.req_rdy), WID'(er));
        if (want[4]) chk("req_rdy_directed", WID'(bus.req_rdy), WID'(want[3:0]));
        if (outs_known) begin
            chk("wr0", WID'(bus.wr0), WID'(m_wr0));
            chk("wr1", WID'(bus.wr1), WID'(m_wr1));
            chk("wa0", WID'(bus.wa0), WID'(m_wa0));
            chk("wa1", WID'(bus.wa1), WID'(m_wa1));
            chk("i0", bus.i0, m_i0);
            chk("i1", bus.i1, m_i1);
            chk("wr_cnt", WID'(bus.wr_cnt), WID'(m_cnt));
            if (bus.wr0 && bus.wr1) chk("wa_distinct", WID'(bus.wa0 != bus.wa1), WID'(1));
        end
        last_gnt = er;
        if (rst) begin
            m_rr = 0; m_wr0 = 0; m_wr1 = 0; m_wa0 = 0; m_wa1 = 0;
            m_i0 = 0; m_i1 = 0; m_cnt = 0;
            outs_known = 1;
        end else begin
            m_cnt = m_cnt + 32'(m_wr0) + 32'(m_wr1);
            m_wr0 = (ga >= 0) && (r_addr[ga][5:0] != 0);
            m_wr1 = (gb >= 0) && (r_addr[gb][5:0] != 0);
            if (ga >= 0) begin m_wa0 = r_addr[ga]; m_i0 = r_data[ga]; end
            if (gb >= 0) begin m_wa1 = r_addr[gb]; m_i1 = r_data[gb]; end
            if (gb >= 0)      m_rr = (gb + 1) % 4;
            else if (ga >= 0) m_rr = (ga + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic [7:0] a, input logic [WID-1:0] d);
        r_addr[n] = a;
        r_data[n] = d;
    endtask

    initial begin
        int wait3;
        int since [4];
        rst = 1'b1; stall = 1'b0; r_v = 4'hF;
        for (int n = 0; n < 4; n++) set_req(n, 8'h11 + 8'(n), {$urandom, $urandom});

        // reset holds grants off even with all requesters valid
        cycle(5'h10);
        cycle(5'h10);
        rst = 1'b0;

        // dual grant with rotation, requests re-presented after each grant
        cycle(5'h13);
        cycle(5'h1C);
        cycle(5'h13);
        r_v = 4'h0;
        cycle(5'h10);
        cycle(5'h10);
        chk("wr_cnt_after_dual", WID'(bus.wr_cnt), WID'(6));

        // address conflict from rr=0
        rst = 1'b1; cycle(5'h10); rst = 1'b0;
        r_v = 4'b0111;
        set_req(0, 8'h20, 64'hA0); set_req(1, 8'h20, 64'hA1); set_req(2, 8'h30, 64'hA2);
        cycle(5'h15);
        r_v = 4'b0010;
        cycle(5'h12);
        r_v = 4'h0;
        cycle(5'h10);
        chk("conflict_wa0", WID'(bus.wa0), WID'(8'h20));
        chk("conflict_i0", bus.i0, 64'hA1);

        // zero register in bank 1, then a real register
        r_v = 4'b0001; set_req(0, 8'h40, 64'hDEAD);
        cycle(5'h11);
        r_v = 4'h0;
        cycle(5'h10);
        r_v = 4'b0001; set_req(0, 8'h41, 64'hDEAD);
        cycle(5'h11);
        r_v = 4'h0;
        cycle(5'h10);
        chk("zero_wa0", WID'(bus.wa0), WID'(8'h41));

        // stall with all requesters valid
        r_v = 4'hF;
        for (int n = 0; n < 4; n++) set_req(n, 8'h50 + 8'(n), {$urandom, $urandom});
        stall = 1'b1;
        repeat (3) cycle(5'h10);
        stall = 1'b0;
        repeat (2) cycle(5'h00);

        // fairness: every requester valid each cycle, no one waits more than one cycle
        for (int n = 0; n < 4; n++) since[n] = 0;
        wait3 = 0;
        repeat (8) begin
            cycle(5'h00);
            for (int n = 0; n < 4; n++) begin
                if (dut_rdy[n]) since[n] = 0;
                else since[n]++;
                chk("fair_wait", WID'(since[n] <= 1), WID'(1));
            end
        end
        r_v = 4'h0;
        cycle(5'h10);

        // randomized traffic with conflicts, zero registers, stalls and resets
        repeat (400) begin
            for (int n = 0; n < 4; n++) begin
                if (!r_v[n] && ($urandom_range(0, 9) < 6)) begin
                    r_v[n] = 1'b1;
                    set_req(n, 8'($urandom_range(0, 255)) & 8'hC7, {$urandom, $urandom});
                end
            end
            stall = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            cycle(5'h00);
            r_v = r_v & ~last_gnt;
        end
        rst = 1'b0; stall = 1'b0; r_v = 4'h0;
        cycle(5'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
